led_breathe: RTL and testbench



---
 rtl/led_breathe.sv | 144 ++++++++++++++
 tb/tb_led_breathe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_breathe.sv
// led_breathe: turns the square-wave blink level into a "breathing" PWM drive
// for the board LED. The duty value ramps up/down one LSB per STEP_DIV clocks,
// and the PWM compare value is shadowed so it only changes at a period start.
//
// Optional build macro LED_BREATHE_GAMMA_EN: when defined, the applied PWM duty
// is the quadratic perceptual curve ((duty+1)*duty) >> PWM_BITS; otherwise the
// ramp value is applied linearly. duty_o always reports the pre-gamma ramp.
//
// state | meaning
// ------+-----------------------------------------------------------
// OFF   | LED target off, duty held at 0, waiting for blink_i = 1
// RISE  | ramping duty up one step per prescaler tick toward MAX
// ON    | LED target full on, duty held at MAX, waiting for blink_i = 0
// FALL  | ramping duty down one step per prescaler tick toward 0

module led_breathe #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 32768
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                blink_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                busy_o
);

    localparam int              PRE_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = DUTY_MAX - 1'b1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    state_t              state_q, state_nx;
    logic [PWM_BITS-1:0] duty_q, duty_nx;
    logic [PRE_W-1:0]    presc_q, presc_nx;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] applied_q, applied_nx;
    logic [PWM_BITS-1:0] gamma_duty;
    logic                led_q;

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_wide;
    logic [2*PWM_BITS-1:0] gamma_prod;

    assign duty_wide  = {{PWM_BITS{1'b0}}, duty_q};
    assign gamma_prod = (duty_wide + 1'b1) * duty_wide;
    assign gamma_duty = gamma_prod[2*PWM_BITS-1:PWM_BITS];
`else
    assign gamma_duty = duty_q;
`endif

    // ramp sequencing: next state, next duty and step prescaler; all frozen while disabled
    always_comb begin
        state_nx = state_q;
        duty_nx  = duty_q;
        presc_nx = presc_q;
        tick     = (presc_q == PRE_LAST);
        if (en_i) begin
            case (state_q)
                ST_OFF: begin
                    if (blink_i) state_nx = ST_RISE;
                end
                ST_RISE: begin
                    if (!blink_i) begin
                        state_nx = ST_FALL;
                    end else if (duty_q == DUTY_MAX) begin
                        state_nx = ST_ON;
                    end else if (tick) begin
                        duty_nx = duty_q + 1'b1;
                        if (duty_q == DUTY_MAX - 1'b1) state_nx = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!blink_i) state_nx = ST_FALL;
                end
                ST_FALL: begin
                    if (blink_i) begin
                        state_nx = ST_RISE;
                    end else if (duty_q == '0) begin
                        state_nx = ST_OFF;
                    end else if (tick) begin
                        duty_nx = duty_q - 1'b1;
                        if (duty_q == {{(PWM_BITS-1){1'b0}}, 1'b1}) state_nx = ST_OFF;
                    end
                end
                default: state_nx = ST_OFF;
            endcase
            // prescaler restarts on every state change so a reversal never steps early
            if ((state_nx != state_q) || !((state_q == ST_RISE) || (state_q == ST_FALL))) begin
                presc_nx = '0;
            end else if (tick) begin
                presc_nx = '0;
            end else begin
                presc_nx = presc_q + 1'b1;
            end
        end
    end

    // compare value for this clock: a new period picks up the fresh duty, otherwise the shadow
    always_comb begin
        applied_nx = applied_q;
        if (pwm_cnt_q == '0) applied_nx = gamma_duty;
    end

    // ramp state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            duty_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_nx;
            duty_q  <= duty_nx;
            presc_q <= presc_nx;
        end
    end

    // free-running PWM counter, duty shadow and registered LED drive
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt_q <= '0;
            applied_q <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
            applied_q <= applied_nx;
            led_q     <= en_i & (pwm_cnt_q < applied_nx);
        end
    end

    assign led_o  = led_q;
    assign duty_o = duty_q;
    assign busy_o = (state_q == ST_RISE) || (state_q == ST_FALL);

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe with PWM_BITS=4, STEP_DIV=4 (MAX=15, PWM period 15).
// Stimulus pushes timed expectations into queues; monitors pop and compare.
module tb_led_breathe;

    localparam int PB = 4;
    localparam int SD = 4;

    logic          clk_i;
    logic          rst_ni;
    logic          en_i;
    logic          blink_i;
    logic          led_o;
    logic [PB-1:0] duty_o;
    logic          busy_o;

    led_breathe #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .blink_i(blink_i),
        .led_o  (led_o),
        .duty_o (duty_o),
        .busy_o (busy_o)
    );

    typedef struct {
        int       cyc;
        logic [2:0] mask;
        int       duty;
        bit       busy;
        bit       led;
        string    name;
    } exp_t;

    typedef struct {
        int    start;
        int    cnt;
        string name;
    } win_t;

    exp_t sq[$];
    win_t wq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // cycles counted since reset release; index k means "after the k-th active edge"
    always @(posedge clk_i) if (rst_ni) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void push(int c, logic [2:0] m, int d, bit b, bit l, string nm);
        exp_t e;
        e.cyc = c; e.mask = m; e.duty = d; e.busy = b; e.led = l; e.name = nm;
        sq.push_back(e);
    endfunction

    function automatic void pushw(int s, int n, string nm);
        win_t w;
        w.start = s; w.cnt = n; w.name = nm;
        wq.push_back(w);
    endfunction

    function automatic int gam(int d);
`ifdef LED_BREATHE_GAMMA_EN
        return ((d + 1) * d) >> PB;
`else
        return d;
`endif
    endfunction

    // sample monitor: compare every expectation whose cycle has come
    initial begin
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < sq.size();) begin
                if (sq[i].cyc <= cyc) begin
                    exp_t e;
                    e = sq[i];
                    if (e.cyc < cyc) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.cyc, cyc);
                    end else begin
                        if (e.mask[0]) chk({e.name, ".duty"}, int'(duty_o), e.duty);
                        if (e.mask[1]) chk({e.name, ".busy"}, int'(busy_o), int'(e.busy));
                        if (e.mask[2]) chk({e.name, ".led"}, int'(led_o), int'(e.led));
                    end
                    sq.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    // PWM window monitor: count led_o highs over one 15-cycle period
    initial begin
        forever begin
            @(negedge clk_i);
            if (wq.size() > 0 && wq[0].start == cyc) begin
                win_t w;
                int   n;
                w = wq.pop_front();
                n = 0;
                for (int j = 0; j < 15; j++) begin
                    if (j > 0) @(negedge clk_i);
                    n += int'(led_o);
                end
                chk(w.name, n, w.cnt);
            end
        end
    end

    task automatic wait_cyc(int n);
        do begin
            @(posedge clk_i);
            #2;
        end while (cyc < n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        en_i    = 1'b1;
        blink_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // idle after reset: everything stays off
        for (int c = 1; c <= 100; c++) push(c, 3'b111, 0, 0, 0, "idle");
        wait_cyc(100);

        // full rise 0 -> 15, then steady full on
        blink_i = 1'b1;
        push(101, 3'b011, 0, 1, 0, "rise_start");
        for (int d = 1; d <= 15; d++) begin
            push(100 + 4*d, 3'b011, d - 1, 1, 0, "rise_hold");
            push(101 + 4*d, 3'b011, d, d < 15, 0, "rise_step");
        end
        pushw(121, gam(4), "rise_pwm4");
        pushw(136, gam(8), "rise_pwm8");
        pushw(151, gam(12), "rise_pwm12");
        for (int c = 166; c <= 200; c++) push(c, 3'b111, 15, 0, 1, "on_const");
        wait_cyc(200);

        // full fall 15 -> 0, then steady off
        blink_i = 1'b0;
        push(201, 3'b011, 15, 1, 0, "fall_start");
        for (int k = 1; k <= 15; k++) begin
            push(200 + 4*k, 3'b011, 16 - k, 1, 0, "fall_hold");
            push(201 + 4*k, 3'b011, 15 - k, k < 15, 0, "fall_step");
        end
        pushw(211, gam(13), "fall_pwm13");
        pushw(226, gam(9), "fall_pwm9");
        pushw(241, gam(6), "fall_pwm6");
        pushw(256, gam(2), "fall_pwm2");
        for (int c = 275; c <= 300; c++) push(c, 3'b111, 0, 0, 0, "off_const");
        wait_cyc(300);

        // reversal at duty 7: fall begins from 7 with no jump
        blink_i = 1'b1;
        push(301, 3'b011, 0, 1, 0, "rev_rise_start");
        push(328, 3'b011, 6, 1, 0, "rev_at6");
        push(329, 3'b011, 7, 1, 0, "rev_at7");
        wait_cyc(329);
        blink_i = 1'b0;
        for (int c = 330; c <= 333; c++) push(c, 3'b011, 7, 1, 0, "rev_nojump");
        push(334, 3'b011, 6, 1, 0, "rev_first_down");
        push(337, 3'b011, 6, 1, 0, "rev_hold6");
        push(338, 3'b011, 5, 1, 0, "rev_down5");
        push(357, 3'b011, 1, 1, 0, "rev_at1");
        push(358, 3'b011, 0, 0, 0, "rev_done");
        wait_cyc(370);

        // enable drop at duty 9 freezes the ramp and blanks the LED
        blink_i = 1'b1;
        push(371, 3'b011, 0, 1, 0, "en_rise_start");
        push(407, 3'b111, 9, 1, 1, "en_pre");
        wait_cyc(407);
        en_i = 1'b0;
        for (int c = 408; c <= 427; c++) push(c, 3'b111, 9, 1, 0, "en_hold");
        wait_cyc(427);
        en_i = 1'b1;
        push(430, 3'b011, 9, 1, 0, "en_resume_hold");
        push(431, 3'b011, 10, 1, 0, "en_resume_step");
        wait_cyc(440);

        // asynchronous reset mid-ramp
        chk("rst_pre.led", int'(led_o), 1);
        chk("rst_pre.duty", int'(duty_o), 12);
        chk("rst_pre.busy", int'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_async.led", int'(led_o), 0);
        chk("rst_async.duty", int'(duty_o), 0);
        chk("rst_async.busy", int'(busy_o), 0);
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        push(441, 3'b011, 0, 1, 0, "rst_rise");
        push(444, 3'b011, 0, 1, 0, "rst_hold");
        push(445, 3'b011, 1, 1, 0, "rst_step");
        wait_cyc(450);

        for (int k = 0; k < 50 && (sq.size() > 0 || wq.size() > 0); k++) @(posedge clk_i);
        if (sq.size() > 0 || wq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d samples and %0d windows left, expected 0", sq.size(), wq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
